i2c_seg_target: RTL

I2C_SEG_TARGET -- requirements
Module: i2c_seg_target

---
 rtl/i2c_seg_target.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_seg_target.sv
// I2C target that drives a 7-segment display from two registers:
// SEG (pattern) and CTRL (blank/invert).
// Raw SCL/SDA are synchronised into clk. Byte-level protocol handling is a
// two-process FSM. The displayed pattern is registered from the current
// register contents.
module i2c_seg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] seg_out,
  output logic       wr_strobe,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic       scl_s1_q, scl_s2_q, scl_h_q;
  logic       sda_s1_q, sda_s2_q, sda_h_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       wr_q, wr_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic [7:0] seg_q, seg_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] seg_out_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte, rd_byte;

  // Two-stage synchronisers plus a history stage for edge detection; idle-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_in;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign rx_byte   = {shift_q[6:0], sda_s2_q};
  assign rd_byte   = ptr_q ? {6'b000000, ctrl_q} : seg_q;

  // Next-state and datapath decisions; START/STOP take priority over every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    wr_d    = 1'b0;
    rw_d    = rw_q;
    mack_d  = mack_q;
    seg_d   = seg_q;
    ctrl_d  = ctrl_q;
    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d = S_ADDR_ACK;
                rw_d    = rx_byte[0];
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          // First fall starts the ACK clock, second fall ends it.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              cnt_d = 4'd0;
              if (rw_q) begin
                state_d = S_RDATA;
                oe_d    = ~rd_byte[7];
                shift_d = {rd_byte[6:0], 1'b0};
              end else begin
                state_d = S_PTR;
                oe_d    = 1'b0;
              end
            end
          end
        end
        S_PTR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (rx_byte[7:1] == 7'd0) begin
                ptr_d   = rx_byte[0];
                state_d = S_PTR_ACK;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              wr_d    = 1'b1;
              ptr_d   = ~ptr_q;
              state_d = S_WDATA_ACK;
              if (ptr_q) ctrl_d = rx_byte[1:0];
              else       seg_d  = rx_byte;
            end
          end
        end
        S_RDATA: begin
          // Bit 7 went out on entry; each fall presents the next bit, the
          // fall after the 8th rise hands SDA back to the master.
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              mack_d  = 1'b0;
              state_d = S_RDATA_ACK;
            end else begin
              oe_d    = ~shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s2_q) begin
              state_d = S_IGNORE;
            end else begin
              mack_d = 1'b1;
              ptr_d  = ~ptr_q;
            end
          end else if (scl_fall && mack_q) begin
            state_d = S_RDATA;
            cnt_d   = 4'd0;
            oe_d    = ~rd_byte[7];
            shift_d = {rd_byte[6:0], 1'b0};
          end
        end
        S_IGNORE: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Protocol state and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      shift_q <= 8'h00;
      ptr_q   <= 1'b0;
      oe_q    <= 1'b0;
      wr_q    <= 1'b0;
      rw_q    <= 1'b0;
      mack_q  <= 1'b0;
      seg_q   <= 8'h00;
      ctrl_q  <= 2'b01;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      mack_q  <= mack_d;
      seg_q   <= seg_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Display pattern follows the registers one cycle later.
  always_ff @(posedge clk) begin
    if (rst) seg_out_q <= 8'h00;
    else     seg_out_q <= ctrl_q[0] ? 8'h00 : (seg_q ^ {8{ctrl_q[1]}});
  end

  assign sda_oe    = oe_q;
  assign wr_strobe = wr_q;
  assign seg_out   = seg_out_q;
  assign busy      = (state_q inside {S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WDATA,
                                      S_WDATA_ACK, S_RDATA, S_RDATA_ACK});

endmodule
